// File: rtl/crc4_serial_rx.sv
// crc4_serial_rx: bit-serial CRC-4 frame receiver and checker.
//
// A frame is NUM_BITS message bits followed by 4 CRC bits, MSB first, one bit
// per clk edge where wr_en=1. The CRC-4 is computed over the message as it
// arrives. Once the last CRC bit is sampled, the received CRC is compared
// with the computed value and the result is published with a one-cycle done
// pulse.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   wr_en    - bit-valid qualifier for data_in
//   data_in  - serial frame bit, MSB first
//   busy     - a frame is partially received
//   done     - one-cycle pulse after the last CRC bit is sampled
//   msg_out  - last completed message, first-received bit in the MSB
//   crc_out  - last received CRC field, first-received bit in bit 3
//   crc_ok   - computed CRC matched crc_out for the last completed frame
module crc4_serial_rx #(
    parameter logic [7:0] NUM_BITS = 8'd3,
    parameter logic [3:0] POLY     = 4'b0011,
    parameter logic [3:0] INIT     = 4'b0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                data_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] msg_out,
    output logic [3:0]          crc_out,
    output logic                crc_ok
);

    typedef enum logic [1:0] {
        StIdle,
        StMsg,
        StCrc
    } state_e;

    localparam logic [7:0] LastMsg = NUM_BITS - 8'd1;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          crc_q, crc_d;
    logic [NUM_BITS-1:0] msg_sr_q, msg_sr_d;
    logic [2:0]          crc_sr_q, crc_sr_d;
    logic                done_q, done_d;
    logic [NUM_BITS-1:0] msg_out_q, msg_out_d;
    logic [3:0]          crc_out_q, crc_out_d;
    logic                crc_ok_q, crc_ok_d;

    logic                fb;
    logic [3:0]          crc_step;
    logic [NUM_BITS-1:0] msg_shift;
    logic [3:0]          crc_rx;

    // A one-bit message has nothing to shift through.
    if (NUM_BITS == 8'd1) begin : g_msg_one
        assign msg_shift = data_in;
    end else begin : g_msg_many
        assign msg_shift = {msg_sr_q[NUM_BITS-2:0], data_in};
    end

    // Serial CRC step: the incoming bit is folded in at the top of the register.
    assign fb       = crc_q[3] ^ data_in;
    assign crc_step = {crc_q[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);

    // Full received CRC field, including the bit being sampled now.
    assign crc_rx   = {crc_sr_q, data_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            crc_q     <= INIT;
            msg_sr_q  <= '0;
            crc_sr_q  <= 3'b000;
            done_q    <= 1'b0;
            msg_out_q <= '0;
            crc_out_q <= 4'b0000;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            msg_sr_q  <= msg_sr_d;
            crc_sr_q  <= crc_sr_d;
            done_q    <= done_d;
            msg_out_q <= msg_out_d;
            crc_out_q <= crc_out_d;
            crc_ok_q  <= crc_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        msg_sr_d  = msg_sr_q;
        crc_sr_d  = crc_sr_q;
        done_d    = 1'b0;
        msg_out_d = msg_out_q;
        crc_out_d = crc_out_q;
        crc_ok_d  = crc_ok_q;

        if (wr_en) begin
            case (state_q)
                StIdle: begin
                    msg_sr_d = msg_shift;
                    crc_d    = crc_step;
                    if (NUM_BITS == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = StCrc;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = StMsg;
                    end
                end
                StMsg: begin
                    msg_sr_d = msg_shift;
                    crc_d    = crc_step;
                    if (cnt_q == LastMsg) begin
                        cnt_d   = 8'd0;
                        state_d = StCrc;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StCrc: begin
                    // Computed CRC stays frozen while the received field shifts in.
                    crc_sr_d = crc_rx[2:0];
                    if (cnt_q == 8'd3) begin
                        msg_out_d = msg_sr_q;
                        crc_out_d = crc_rx;
                        crc_ok_d  = (crc_q == crc_rx);
                        done_d    = 1'b1;
                        crc_d     = INIT;
                        cnt_d     = 8'd0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    crc_d   = INIT;
                end
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign msg_out = msg_out_q;
    assign crc_out = crc_out_q;
    assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc4_serial_rx.sv
// Directed bench for crc4_serial_rx: default 3-bit instance plus an 8-bit instance.
module tb_crc4_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       data_in = 1'b0;
    logic       busy, done, crc_ok;
    logic [2:0] msg_out;
    logic [3:0] crc_out;

    logic       wr_en8 = 1'b0;
    logic       data_in8 = 1'b0;
    logic       busy8, done8, crc_ok8;
    logic [7:0] msg_out8;
    logic [3:0] crc_out8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc4_serial_rx dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .msg_out (msg_out),
        .crc_out (crc_out),
        .crc_ok  (crc_ok)
    );

    crc4_serial_rx #(.NUM_BITS(8'd8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en8),
        .data_in (data_in8),
        .busy    (busy8),
        .done    (done8),
        .msg_out (msg_out8),
        .crc_out (crc_out8),
        .crc_ok  (crc_ok8)
    );

    // Good frame 101 + CRC 1111, bad frame 101 + CRC 1110.
    logic [6:0] good_frame = 7'b1011111;
    logic [6:0] bad_frame  = 7'b1011110;

    task automatic send_bit(input logic b);
        wr_en   = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic send_bit8(input logic b);
        wr_en8   = 1'b1;
        data_in8 = b;
        @(posedge clk);
        #1;
        wr_en8   = 1'b0;
    endtask

    task automatic idle_cycle();
        wr_en  = 1'b0;
        wr_en8 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            data_in = i[0];
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, msg_out, crc_out, crc_ok} !== 10'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: busy=%b done=%b msg=%b crc=%b ok=%b, required all 0",
                         i, busy, done, msg_out, crc_out, crc_ok);
            end
            checks++;
            if ({busy8, done8, msg_out8, crc_out8, crc_ok8} !== 15'b0) begin
                errors++;
                $display("FAIL reset8 cyc%0d: busy=%b done=%b msg=%h crc=%b ok=%b, required all 0",
                         i, busy8, done8, msg_out8, crc_out8, crc_ok8);
            end
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        for (int i = 6; i >= 0; i--) begin
            send_bit(good_frame[i]);
            if (i > 0) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL good mid bit%0d: busy=%b done=%b, required busy=1 done=0",
                             6 - i, busy, done);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || msg_out !== 3'b101 || crc_out !== 4'b1111
            || crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL good end: done=%b busy=%b msg=%b crc=%b ok=%b, required 1 0 101 1111 1",
                     done, busy, msg_out, crc_out, crc_ok);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b0 || crc_ok !== 1'b1 || msg_out !== 3'b101) begin
            errors++;
            $display("FAIL good pulse: done=%b msg=%b ok=%b, required done=0 msg=101 ok=1",
                     done, msg_out, crc_ok);
        end
    endtask

    task automatic test_bad_crc();
        for (int i = 6; i >= 0; i--) begin
            send_bit(bad_frame[i]);
            if (i > 0) begin
                checks++;
                if (done !== 1'b0 || crc_ok !== 1'b1 || crc_out !== 4'b1111) begin
                    errors++;
                    $display("FAIL bad hold bit%0d: done=%b crc=%b ok=%b, required 0 1111 1",
                             6 - i, done, crc_out, crc_ok);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || msg_out !== 3'b101 || crc_out !== 4'b1110 || crc_ok !== 1'b0) begin
            errors++;
            $display("FAIL bad end: done=%b msg=%b crc=%b ok=%b, required 1 101 1110 0",
                     done, msg_out, crc_out, crc_ok);
        end
        idle_cycle();
    endtask

    task automatic test_gaps();
        int early = 0;
        for (int i = 6; i >= 0; i--) begin
            int gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                idle_cycle();
                if (done !== 1'b0) early++;
            end
            send_bit(good_frame[i]);
            if (i > 0 && done !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL gaps early: %0d early done cycles, required 0", early);
        end
        checks++;
        if (done !== 1'b1 || msg_out !== 3'b101 || crc_out !== 4'b1111 || crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL gaps end: done=%b msg=%b crc=%b ok=%b, required 1 101 1111 1",
                     done, msg_out, crc_out, crc_ok);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL gaps twice: done=%b, required 0", done);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 6; i >= 0; i--) send_bit(good_frame[i]);
        checks++;
        if (done !== 1'b1 || crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b first: done=%b ok=%b, required 1 1", done, crc_ok);
        end
        // Next frame starts in the done cycle.
        for (int i = 6; i >= 0; i--) begin
            send_bit(bad_frame[i]);
            if (i > 0) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || msg_out !== 3'b101 || crc_out !== 4'b1111
                    || crc_ok !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b hold bit%0d: done=%b busy=%b msg=%b crc=%b ok=%b, req 0 1 101 1111 1",
                             6 - i, done, busy, msg_out, crc_out, crc_ok);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || msg_out !== 3'b101 || crc_out !== 4'b1110 || crc_ok !== 1'b0) begin
            errors++;
            $display("FAIL b2b second: done=%b msg=%b crc=%b ok=%b, required 1 101 1110 0",
                     done, msg_out, crc_out, crc_ok);
        end
        idle_cycle();
    endtask

    task automatic test_num_bits8();
        logic [11:0] good8;
        logic [11:0] bad8;
        good8 = {8'hA5, 4'b1011};
        bad8  = {8'hA5, 4'b1010};
        for (int i = 11; i >= 0; i--) begin
            send_bit8(good8[i]);
            if (i > 0) begin
                checks++;
                if (done8 !== 1'b0 || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL nb8 mid bit%0d: done=%b busy=%b, required 0 1",
                             11 - i, done8, busy8);
                end
            end
        end
        checks++;
        if (done8 !== 1'b1 || msg_out8 !== 8'hA5 || crc_out8 !== 4'b1011 || crc_ok8 !== 1'b1) begin
            errors++;
            $display("FAIL nb8 good: done=%b msg=%h crc=%b ok=%b, required 1 a5 1011 1",
                     done8, msg_out8, crc_out8, crc_ok8);
        end
        for (int i = 11; i >= 0; i--) send_bit8(bad8[i]);
        checks++;
        if (done8 !== 1'b1 || msg_out8 !== 8'hA5 || crc_out8 !== 4'b1010 || crc_ok8 !== 1'b0) begin
            errors++;
            $display("FAIL nb8 bad: done=%b msg=%h crc=%b ok=%b, required 1 a5 1010 0",
                     done8, msg_out8, crc_out8, crc_ok8);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 6; i >= 3; i--) send_bit(good_frame[i]);
        // Reset wins over a valid bit in the same cycle.
        rst     = 1'b1;
        wr_en   = 1'b1;
        data_in = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        checks++;
        if ({busy, done, msg_out, crc_out, crc_ok} !== 10'b0) begin
            errors++;
            $display("FAIL rstmid clear: busy=%b done=%b msg=%b crc=%b ok=%b, required all 0",
                     busy, done, msg_out, crc_out, crc_ok);
        end
        for (int i = 6; i >= 0; i--) begin
            send_bit(good_frame[i]);
            if (i > 0) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid early bit%0d: done=%b, required 0", 6 - i, done);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || msg_out !== 3'b101 || crc_out !== 4'b1111 || crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid end: done=%b msg=%b crc=%b ok=%b, required 1 101 1111 1",
                     done, msg_out, crc_out, crc_ok);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_gaps();
        test_back_to_back();
        test_num_bits8();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
